// File: rtl/seq_det_param_if.sv
// Serial-stream bus of the parametrised pattern detector.
// Stream qualification: x is consumed on a rising clock edge only when en=1.
// pat_load takes priority over en. There is no back-pressure, because the
// detector accepts a bit on every enabled cycle. y, match_cnt and cnt_sat are
// status outputs and are valid on every cycle.
interface seq_det_param_if #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 8
);
   logic             en;
   logic             x;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic             y;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   modport master (
      output en, x, pat_load, pat_in,
      input  y, match_cnt, cnt_sat
   );

   modport slave (
      input  en, x, pat_load, pat_in,
      output y, match_cnt, cnt_sat
   );
endinterface

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with a reloadable pattern.
// The window holds the last PAT_W-1 accepted bits, and the bit on x completes it.
// r_fill counts the fresh bits collected since the last restart and saturates
// at PAT_W-1. A match is only possible once the window is full.
module seq_det_param #(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter bit               OVERLAP = 1'b1,
   parameter bit               MOORE   = 1'b0,
   parameter int               CNT_W   = 8
) (
   input logic             clk,
   input logic             rst,
   seq_det_param_if.slave  bus
);
   localparam int                FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  r_pat;
   logic [CNT_W-1:0]  r_cnt;

   logic [PAT_W-1:0]  w_win;
   logic              w_match;
   logic              w_sat;

   // Form the candidate window from the history plus the incoming bit, and test it.
   always_comb begin
      w_win   = {r_hist, bus.x};
      w_sat   = &r_cnt;
      w_match = bus.en & ~bus.pat_load & (r_fill == FILL_MAX) & (w_win == r_pat);
   end

   // Update the pattern, history, fill and counter. A load wins over a data bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= PATTERN;
         r_cnt  <= '0;
      end else if (bus.pat_load) begin
         r_pat  <= bus.pat_in;
         r_hist <= '0;
         r_fill <= '0;
      end else if (bus.en) begin
         r_hist <= w_win[PAT_W-2:0];
         if (w_match && !OVERLAP) begin
            r_fill <= '0;
         end else if (r_fill != FILL_MAX) begin
            r_fill <= r_fill + 1'b1;
         end
         if (w_match && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   generate
      if (MOORE) begin : g_moore
         logic r_yq;

         // Registered match flag. It advances only on enabled cycles, so it
         // holds its value across gaps where en=0.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_yq <= 1'b0;
            end else if (bus.pat_load) begin
               r_yq <= 1'b0;
            end else if (bus.en) begin
               r_yq <= w_match;
            end
         end

         assign bus.y = r_yq;
      end else begin : g_mealy
         assign bus.y = w_match;
      end
   endgenerate

   assign bus.match_cnt = r_cnt;
   assign bus.cnt_sat   = w_sat;
endmodule
